// File: rtl/pulse_gen_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_gen_scheduler
//
// Purpose:
//   Round-robin arbiter and job controller for a shared 16-bit circular pulse
//   generator. A granted request loads its pattern into the generator (one
//   LOAD cycle). The pattern then rotates for (repeat+1) full 16-cycle periods
//   (RUN), after which the generator is released back to IDLE.
//
// Ports:
//   clock         system clock, all state changes on posedge
//   reset         synchronous, active-high reset
//   req0_valid    requester 0 has a request
//   req0_pattern  requester 0 16-bit pattern
//   req0_repeat   requester 0 repeat count (rotations = repeat+1)
//   req0_ready    requester 0 accepted this cycle (combinational)
//   req1_*        same as req0_* for requester 1
//   abort         cancel the current job (ignored in IDLE)
//   gen_in        pattern to the generator's parallel input
//   gen_load      generator load_flag
//   busy          high in LOAD and RUN
//   owner         index of the current or last granted requester
//   done          one-cycle pulse in the final RUN cycle of a completed job
//
// Build option:
//   PULSE_GEN_CLEAR_ON_IDLE_EN - when defined, every LOAD/RUN->IDLE transition
//   spends its first IDLE cycle loading 16'h0000 into the generator, and
//   accepts are blocked during that one cycle. Reset never triggers a clear.
// -----------------------------------------------------------------------------
module pulse_gen_scheduler #(
  parameter int REP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [15:0]      req0_pattern,
  input  logic [REP_W-1:0] req0_repeat,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_pattern,
  input  logic [REP_W-1:0] req1_repeat,
  output logic             req1_ready,
  input  logic             abort,
  output logic [15:0]      gen_in,
  output logic             gen_load,
  output logic             busy,
  output logic             owner,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_last_grant;
  logic             r_owner;
  logic [15:0]      r_pat;
  logic [REP_W-1:0] r_rep_left;
  logic [3:0]       r_bit_cnt;

  logic             w_idle_open;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_final;

  // ---------------------------------------------------------------------------
  // Clear-on-idle bookkeeping: r_clear marks the first IDLE cycle after a job
  // ends (completion or abort). Reset forces it low, so a reset never clears.
  // ---------------------------------------------------------------------------
`ifdef PULSE_GEN_CLEAR_ON_IDLE_EN
  logic r_clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clear <= 1'b0;
    end else begin
      r_clear <= (r_state != S_IDLE) && (w_state_next == S_IDLE);
    end
  end

  assign w_idle_open = (r_state == S_IDLE) && !r_clear && !reset;
`else
  assign w_idle_open = (r_state == S_IDLE) && !reset;
`endif

  // Round-robin: with both requesters valid, the one not granted last wins.
  // r_last_grant resets to 1 so requester 0 wins the first contest.
  assign w_grant0 = w_idle_open && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_idle_open && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept = w_grant0 || w_grant1;

  // Last cycle of the last rotation period.
  assign w_final  = (r_state == S_RUN) && (r_bit_cnt == 4'hF) && (r_rep_left == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort || w_final) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // done is gated by abort so an abort landing on the would-be final cycle
  // cancels the completion pulse; the job counts as aborted, not completed.
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    busy       = (r_state != S_IDLE);
    gen_load   = (r_state == S_LOAD);
    gen_in     = r_pat;
    owner      = r_owner;
    done       = w_final && !abort;
`ifdef PULSE_GEN_CLEAR_ON_IDLE_EN
    if (r_clear) begin
      gen_load = 1'b1;
      gen_in   = 16'h0000;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath: request capture, rotation counters
  // rep_left counts remaining extra periods and bit_cnt is a free 4-bit wrap,
  // so repeat = 2^REP_W-1 fits without any wider counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_pat        <= 16'h0000;
      r_rep_left   <= '0;
      r_bit_cnt    <= 4'd0;
    end else begin
      if (w_accept) begin
        r_pat        <= w_grant1 ? req1_pattern : req0_pattern;
        r_rep_left   <= w_grant1 ? req1_repeat  : req0_repeat;
        r_owner      <= w_grant1;
        r_last_grant <= w_grant1;
      end
      case (r_state)
        S_LOAD: begin
          r_bit_cnt <= 4'd0;
        end
        S_RUN: begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if ((r_bit_cnt == 4'hF) && (r_rep_left != '0)) begin
            r_rep_left <= r_rep_left - REP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
